// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register command path.
// Holds the data-width default, the control encoding and the FSM state type.
package shift_pkg;

  localparam int SR_WIDTH = 4;
  localparam int SR_CNT_W = 3;

  // {load, mode} encoding, fixed by the downstream register
  localparam logic [1:0] CTL_HOLD = 2'b00;
  localparam logic [1:0] CTL_SHR  = 2'b01;
  localparam logic [1:0] CTL_SHL  = 2'b10;
  localparam logic [1:0] CTL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // dir=1 shifts toward the MSB
  function automatic logic [1:0] shift_ctl(input logic dir);
    return dir ? CTL_SHL : CTL_SHR;
  endfunction

endpackage

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the bidirectional shift register.
// Ports: clk/reset; cmd_valid/cmd_ready/cmd_data/cmd_dir/cmd_count in;
// sr_load/sr_mode/sr_in to the register; shadow_q, busy, done status.
import shift_pkg::*;

module shift_cmd_sequencer #(
  parameter int WIDTH = SR_WIDTH,
  parameter int CNT_W = SR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sr_load,
  output logic             sr_mode,
  output logic [WIDTH-1:0] sr_in,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNT_W-1:0] rem_q;

  // Logical shift with zero fill, same as the register
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] v,
    input logic             dir
  );
    return dir ? {v[WIDTH-2:0], 1'b0}
               : {1'b0, v[WIDTH-1:1]};
  endfunction

  // Every output is a register updated alongside the state,
  // so nothing on cmd_* reaches sr_* without a flop between.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      shadow_q  <= '0;
      sr_load   <= 1'b0;
      sr_mode   <= 1'b0;
      sr_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            data_q    <= cmd_data;
            dir_q     <= cmd_dir;
            rem_q     <= cmd_count;
            state     <= ST_LOAD;
            {sr_load, sr_mode} <= CTL_LOAD;
            sr_in     <= cmd_data;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          shadow_q <= data_q;
          sr_in    <= '0;
          if (rem_q != '0) begin
            state <= ST_SHIFT;
            {sr_load, sr_mode} <= shift_ctl(dir_q);
          end else begin
            state <= ST_DONE;
            {sr_load, sr_mode} <= CTL_HOLD;
            done  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          shadow_q <= step(shadow_q, dir_q);
          rem_q    <= rem_q - CNT_W'(1);
          // last shift cycle when one remains
          if (rem_q == CNT_W'(1)) begin
            state <= ST_DONE;
            {sr_load, sr_mode} <= CTL_HOLD;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          {sr_load, sr_mode} <= CTL_HOLD;
          sr_in     <= '0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
